// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the data-memory port and its helpers.
//   dmem_state_e      - states of the data-memory port FSM
//   DMEM_TIMEOUT_CYC  - default bus cycles without ack before a transaction is aborted
//   is_misaligned()   - word-alignment test on a byte address
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } dmem_state_e;

    localparam int unsigned DMEM_TIMEOUT_CYC = 64;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_port_bus_timer.sv
// bus_timer: 8-bit wait counter used to abort bus transactions that never see an ack.
//   clk, reset - clock and synchronous active-high reset
//   clear      - force the count back to zero (takes priority over enable)
//   enable     - count one waited bus cycle
//   expired    - high in the LIMIT-th consecutive enabled cycle; the count then holds
module bus_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count is the number of wait cycles already completed, so the
    // LIMIT-th wait cycle is the one where the count reads LIMIT-1.
    localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign expired = (count_q == LIMIT_M1);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_port.sv
// dmem_port: memory-stage load/store port bridging the pipeline to a single-outstanding bus.
//   clk, reset              - clock and synchronous active-high reset
//   req_valid/write/addr/wdata - load/store request from the memory stage (held while stall=1)
//   stall                   - combinational pipeline freeze
//   rdata, rdata_valid      - load result and its one-cycle completion pulse
//   err                     - sticky misalignment/timeout flag, cleared only by reset
//   bus_req/we/addr/wdata   - registered bus request, held until ack is sampled
//   bus_ack, bus_rdata      - bus completion pulse and read data
// Stores are posted: the bus address/data registers act as the one-entry write
// buffer, occupied exactly while the FSM is in WR_WAIT.
module dmem_port
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DMEM_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    dmem_state_e state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic waiting;
    logic expired;
    logic ack_seen;

    assign waiting  = (state_q == WR_WAIT) || (state_q == RD_WAIT);
    // An ack only counts while a request is actually on the bus.
    assign ack_seen = bus_ack && bus_req_q;

    bus_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_bus_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (expired)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        stall       = 1'b0;
        rdata_valid = 1'b0;
        rdata       = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_addr)) begin
                        // Rejected without a bus cycle; a load completes at once with zero.
                        err_d = 1'b1;
                        if (!req_write) begin
                            rdata_valid = 1'b1;
                            rdata       = '0;
                            rdata_d     = '0;
                        end
                    end else if (req_write) begin
                        // Posted store: the pipeline moves on while the bus works.
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b1;
                        bus_addr_d  = req_addr;
                        bus_wdata_d = req_wdata;
                        state_d     = WR_WAIT;
                    end else begin
                        stall      = 1'b1;
                        bus_req_d  = 1'b1;
                        bus_we_d   = 1'b0;
                        bus_addr_d = req_addr;
                        state_d    = RD_WAIT;
                    end
                end
            end
            WR_WAIT: begin
                // The buffer is full, so any new request waits for it to drain.
                stall = req_valid;
                if (ack_seen) begin
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (expired) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_WAIT: begin
                stall = 1'b1;
                if (ack_seen) begin
                    bus_req_d = 1'b0;
                    rdata_d   = bus_rdata;
                    state_d   = RD_DONE;
                end else if (expired) begin
                    bus_req_d = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    state_d   = RD_DONE;
                end
            end
            RD_DONE: begin
                // The held load retires this cycle.
                rdata_valid = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: self-checking bench for dmem_port. Load results are predicted into
// a queue when a load is issued and checked by a monitor on every rdata_valid pulse.
module tb_dmem_port;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    dmem_port #(
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test to finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every completion must match the oldest predicted load.
    always @(negedge clk) begin
        logic [31:0] exp_d;
        if (reset === 1'b0 && rdata_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rdata_valid_unexpected: got pulse with rdata=%h, expected no completion", rdata);
            end else begin
                exp_d = exp_q.pop_front();
                if (rdata !== exp_d) begin
                    n_fail++;
                    $display("FAIL rdata_value: got %h, expected %h", rdata, exp_d);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, expected 0", stall); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b, expected 0", bus_req); end
        n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we: got %b, expected 0", bus_we); end
        n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %h, expected 0", bus_addr); end
        n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus_wdata: got %h, expected 0", bus_wdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h, expected 0", rdata); end
        n_checks++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_valid: got %b, expected 0", rdata_valid); end
        next_cycle();
    endtask

    // Issues one aligned load and acks it in wait cycle ack_cyc (ack_cyc<0: never).
    // The request is cycle 0; bus_req must be high in cycles 1..last, and the
    // pipeline is stalled from cycle 0 through last.
    task automatic run_load(input string name, input logic [31:0] addr, input int ack_cyc,
                            input logic [31:0] data, input bit spurious);
        int   last;
        int   stall_cnt;
        int   cyc;
        bit   released;
        logic exp_req;
        logic [31:0] exp_data;
        last      = (ack_cyc > 0) ? ack_cyc : TIMEOUT;
        exp_data  = (ack_cyc > 0) ? data : 32'h0;
        exp_q.push_back(exp_data);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_wdata = $urandom;
        stall_cnt = 0;
        released  = 1'b0;
        cyc       = 0;
        while (!released && cyc <= last + 4) begin
            bus_ack   = (cyc == ack_cyc) || (spurious && cyc == 0);
            bus_rdata = (cyc == ack_cyc) ? data : $urandom;
            @(negedge clk);
            exp_req = (cyc >= 1 && cyc <= last);
            n_checks++;
            if (bus_req !== exp_req) begin
                n_fail++;
                $display("FAIL %s_bus_req: cycle %0d got %b, expected %b", name, cyc, bus_req, exp_req);
            end
            if (exp_req) begin
                n_checks++;
                if (bus_addr !== addr || bus_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_bus_cmd: cycle %0d got addr=%h we=%b, expected addr=%h we=0",
                             name, cyc, bus_addr, bus_we, addr);
                end
            end
            if (stall === 1'b1) stall_cnt++;
            else released = 1'b1;
            next_cycle();
            cyc++;
        end
        idle_inputs();
        n_checks++;
        if (!released || stall_cnt != last + 1) begin
            n_fail++;
            $display("FAIL %s_stall_cycles: got %0d (released=%0d), expected %0d", name, stall_cnt, released, last + 1);
        end
        @(negedge clk);
        n_checks++;
        if (rdata_valid !== 1'b0 || rdata !== exp_data) begin
            n_fail++;
            $display("FAIL %s_hold: got valid=%b rdata=%h, expected valid=0 rdata=%h", name, rdata_valid, rdata, exp_data);
        end
        next_cycle();
    endtask

    task automatic test_load_basic();
        run_load("load_ack3", 32'h0000_0100, 3, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL load_ack3_err: got %b, expected 0", err); end
        next_cycle();
    endtask

    task automatic test_load_min_latency();
        // An ack in the request cycle arrives before bus_req and must be ignored.
        run_load("load_ack1", 32'h0000_0180, 1, 32'h1357_2468, 1'b1);
    endtask

    // Posted store, then a load that must wait for the write to drain.
    task automatic test_store_then_load();
        bit          exp_stall [6] = '{0, 1, 1, 1, 1, 0};
        bit          exp_req   [6] = '{0, 1, 1, 0, 1, 0};
        bit          exp_we    [6] = '{0, 1, 1, 0, 0, 0};
        logic [31:0] exp_addr  [6] = '{32'h0, 32'h200, 32'h200, 32'h0, 32'h204, 32'h0};
        exp_q.push_back(32'h0BAD_F00D);
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_write = (c == 0);
            req_addr  = (c == 0) ? 32'h200 : 32'h204;
            req_wdata = (c == 0) ? 32'h1234_5678 : 32'h0;
            bus_ack   = (c == 2) || (c == 4);
            bus_rdata = (c == 4) ? 32'h0BAD_F00D : 32'hFFFF_FFFF;
            @(negedge clk);
            n_checks++;
            if (stall !== exp_stall[c] || bus_req !== exp_req[c]) begin
                n_fail++;
                $display("FAIL st_ld_ctrl: cycle %0d got stall=%b bus_req=%b, expected stall=%b bus_req=%b",
                         c, stall, bus_req, exp_stall[c], exp_req[c]);
            end
            if (exp_req[c]) begin
                n_checks++;
                if (bus_we !== exp_we[c] || bus_addr !== exp_addr[c] ||
                    (exp_we[c] && bus_wdata !== 32'h1234_5678)) begin
                    n_fail++;
                    $display("FAIL st_ld_bus: cycle %0d got we=%b addr=%h wdata=%h, expected we=%b addr=%h",
                             c, bus_we, bus_addr, bus_wdata, exp_we[c], exp_addr[c]);
                end
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (rdata !== 32'h0BAD_F00D || rdata_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL st_ld_after: got rdata=%h valid=%b err=%b, expected 0badf00d/0/0", rdata, rdata_valid, err);
        end
        next_cycle();
    endtask

    // Two stores in a row: the second stalls while the first is still buffered.
    task automatic test_back_to_back();
        bit          exp_stall [5] = '{0, 1, 0, 0, 0};
        bit          exp_req   [5] = '{0, 1, 0, 1, 0};
        logic [31:0] exp_addr  [5] = '{32'h0, 32'h500, 32'h0, 32'h504, 32'h0};
        logic [31:0] exp_wdat  [5] = '{32'h0, 32'h1111_1111, 32'h0, 32'h2222_2222, 32'h0};
        for (int c = 0; c < 5; c++) begin
            req_valid = (c <= 2);
            req_write = 1'b1;
            req_addr  = (c == 0) ? 32'h500 : 32'h504;
            req_wdata = (c == 0) ? 32'h1111_1111 : 32'h2222_2222;
            bus_ack   = (c == 1) || (c == 3);
            @(negedge clk);
            n_checks++;
            if (stall !== exp_stall[c] || bus_req !== exp_req[c]) begin
                n_fail++;
                $display("FAIL b2b_ctrl: cycle %0d got stall=%b bus_req=%b, expected stall=%b bus_req=%b",
                         c, stall, bus_req, exp_stall[c], exp_req[c]);
            end
            if (exp_req[c]) begin
                n_checks++;
                if (bus_we !== 1'b1 || bus_addr !== exp_addr[c] || bus_wdata !== exp_wdat[c]) begin
                    n_fail++;
                    $display("FAIL b2b_bus: cycle %0d got we=%b addr=%h wdata=%h, expected we=1 addr=%h wdata=%h",
                             c, bus_we, bus_addr, bus_wdata, exp_addr[c], exp_wdat[c]);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_misaligned();
        // Misaligned store: no bus cycle, no stall, err set.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h201; req_wdata = 32'h7777_7777;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_st_ctrl: got stall=%b bus_req=%b, expected 0/0", stall, bus_req);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_st_err: got err=%b bus_req=%b, expected 1/0", err, bus_req);
        end
        next_cycle();
        // Misaligned load: immediate completion with zero data.
        exp_q.push_back(32'h0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h102;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || rdata_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_ld_ctrl: got stall=%b bus_req=%b valid=%b, expected 0/0/1", stall, bus_req, rdata_valid);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus_req !== 1'b0 || rdata_valid !== 1'b0 || err !== 1'b1 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mis_ld_after: got bus_req=%b valid=%b err=%b rdata=%h, expected 0/0/1/0",
                     bus_req, rdata_valid, err, rdata);
        end
        next_cycle();
    endtask

    task automatic test_write_timeout();
        logic exp_req;
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            req_valid = (c == 0);
            req_write = 1'b1;
            req_addr  = 32'h400;
            req_wdata = 32'hA5A5_A5A5;
            bus_ack   = (c == 5);   // late ack after the abort
            @(negedge clk);
            exp_req = (c >= 1 && c <= TIMEOUT);
            n_checks++;
            if (bus_req !== exp_req || stall !== 1'b0 || err !== (c > TIMEOUT)) begin
                n_fail++;
                $display("FAIL wr_to_ctrl: cycle %0d got bus_req=%b stall=%b err=%b, expected %b/0/%b",
                         c, bus_req, stall, err, exp_req, (c > TIMEOUT));
            end
            if (exp_req) begin
                n_checks++;
                if (bus_we !== 1'b1 || bus_addr !== 32'h400 || bus_wdata !== 32'hA5A5_A5A5) begin
                    n_fail++;
                    $display("FAIL wr_to_bus: cycle %0d got we=%b addr=%h wdata=%h, expected 1/400/a5a5a5a5",
                             c, bus_we, bus_addr, bus_wdata);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_read_timeout();
        apply_reset();
        run_load("rd_timeout", 32'h0000_0104, -1, 32'h0, 1'b0);
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rd_timeout_err: got %b, expected 1", err); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300;
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got bus_req=%b, expected 1", bus_req); end
        next_cycle();
        reset = 1'b1; req_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_drop: got bus_req=%b stall=%b, expected 0/0", bus_req, stall);
        end
        next_cycle();
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        @(negedge clk);
        n_checks++;
        if (rdata_valid !== 1'b0 || bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ack: got valid=%b bus_req=%b, expected 0/0", rdata_valid, bus_req);
        end
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdata_valid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got valid=%b err=%b rdata=%h stall=%b, expected 0/0/0/0",
                     rdata_valid, err, rdata, stall);
        end
        next_cycle();
        // The port must be back in IDLE: a fresh load sees minimum latency.
        run_load("load_after_rst", 32'h0000_0300, 1, 32'h89AB_CDEF, 1'b0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_load_basic();
        test_load_min_latency();
        test_store_then_load();
        test_back_to_back();
        test_misaligned();
        test_write_timeout();
        test_read_timeout();
        test_reset_mid_read();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d loads never completed, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, is the number of bus cycles without bus_ack before a transaction is aborted (legal range 2..255).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high; the clock is clk.
REQ-004 req_valid  in  1  the memory stage presents a load or store this cycle; it is held stable while stall=1.
REQ-005 req_write  in  1  1=store, 0=load.
REQ-006 req_addr  in  32  byte address, word-aligned.
REQ-007 req_wdata  in  32  store data.
REQ-008 stall  out  1  combinational; freezes the pipeline (feeds AnyStall).
REQ-009 rdata  out  32  load result, valid when rdata_valid=1.
REQ-010 rdata_valid  out  1  one-cycle pulse on load completion.
REQ-011 err  out  1  sticky error flag (misaligned access or timeout); cleared only by reset.
REQ-012 bus_req, bus_we  out  1 each  registered bus request and write-enable.
REQ-013 bus_addr, bus_wdata  out  32 each  registered bus address and write data.
REQ-014 bus_ack  in  1  one-cycle completion pulse.
REQ-015 bus_rdata  in  32  read data, valid with bus_ack.

Function
REQ-016 The FSM SHALL have four states: IDLE, WR_WAIT, RD_WAIT and RD_DONE.
REQ-017 Store in IDLE: stall=0; addr/wdata captured into a one-entry posted write buffer; go to WR_WAIT; bus_req=1, bus_we=1 from the next cycle.
REQ-018 Load in IDLE: stall=1; go to RD_WAIT; bus_req=1, bus_we=0 from the next cycle.
REQ-019 bus_req, bus_we, bus_addr and bus_wdata SHALL hold stable until bus_ack is sampled high; bus_req SHALL be 0 in the cycle after the ack.
REQ-020 WR_WAIT + ack: go to IDLE; any request pending during WR_WAIT sees stall=1, then is accepted in the following IDLE cycle.
REQ-021 RD_WAIT + ack: capture bus_rdata into rdata; go to RD_DONE; stall=1 throughout RD_WAIT.
REQ-022 RD_DONE: stall=0, rdata_valid=1 for exactly one cycle; consume the held load; go to IDLE.
REQ-023 Minimum load latency: request cycle N, ack at N+1, rdata_valid at N+2; total stall = 2 cycles.
REQ-024 Misaligned req_addr[1:0]!=0 in IDLE: no bus cycle, set err, stall=0; loads additionally give rdata=0 and rdata_valid=1 in the same cycle.
REQ-025 A wait counter SHALL run in WR_WAIT and RD_WAIT; when it reaches TIMEOUT_CYC without ack, drop bus_req and set err.
REQ-026 Write timeout: go to IDLE.
REQ-027 Read timeout: rdata=0 and go to RD_DONE.
REQ-028 bus_ack while bus_req=0 (late or spurious) SHALL be ignored.
REQ-029 req_valid=0 in IDLE: no state change, stall=0.
REQ-030 rdata SHALL hold its last value until the next load completes.

Reset
REQ-031 Reset values: state=IDLE, write buffer empty, counter=0, err=0, rdata=0, rdata_valid=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0; stall=0 the cycle after reset.
REQ-032 Reset mid-transaction: abandon it; bus_req=0 the next cycle; an ack arriving after reset has no effect.

Structure
REQ-033 The state enum and the default TIMEOUT_CYC constant SHALL live in the shared package mips_pkg.
REQ-034 One sub-module, bus_timer: an 8-bit wait counter with clear/enable inputs and an expired output.
REQ-035 No latches; a single registered FSM plus the combinational stall decode.

Verification
REQ-036 Load addr 0x100, ack at +3 with rdata 0xCAFEF00D -> stall high 4 cycles; rdata_valid one cycle; rdata=0xCAFEF00D.
REQ-037 Store 0x200/0x12345678, then load 0x204 next cycle, write ack at +2 -> store not stalled; load stalls until write ack; read issues after.
REQ-038 Load 0x102 (misaligned) -> no bus_req; err=1; rdata_valid=1 with rdata=0; stall=0.
REQ-039 TIMEOUT_CYC=4, load with no ack -> bus_req drops after 4 cycles; err=1; rdata=0 valid; pipeline released.
REQ-040 Reset in RD_WAIT, ack 2 cycles later -> bus_req=0; state IDLE; rdata_valid stays 0; err=0.
